// File: rtl/muldiv_unit.sv
// Radix-2 iterative multiply/divide unit owning the HI/LO registers.
// Optional MULDIV_FAST_MUL_EN: single-cycle combinational multiply path.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic             flush,
    input  logic             hiwe,
    input  logic             lowe,
    input  logic [WIDTH-1:0] wd,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t             state, state_next;
    logic [CW-1:0]      count;
    logic               is_div;
    logic               qsign, rsign;
    logic [WIDTH-1:0]   opa, opb;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   rem, quo;

    logic               is_signed;
    logic [WIDTH-1:0]   a_abs, b_abs;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift, div_diff;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    assign is_signed = ~op[0];
    assign a_abs     = (is_signed && srca[WIDTH-1]) ? -srca : srca;
    assign b_abs     = (is_signed && srcb[WIDTH-1]) ? -srcb : srcb;

    assign mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, opa} : '0);
    // Partial remainder stays below the divisor, so bit WIDTH of the difference is the borrow.
    assign div_shift = {rem, quo[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, opb};

    assign prod_fix  = qsign ? -prod : prod;
    assign quo_fix   = qsign ? -quo  : quo;
    assign rem_fix   = rsign ? -rem  : rem;

`ifdef MULDIV_FAST_MUL_EN
    logic [2*WIDTH-1:0] fast_prod;
    assign fast_prod = {{WIDTH{1'b0}}, a_abs} * {{WIDTH{1'b0}}, b_abs};
`endif

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: if (start) begin
`ifdef MULDIV_FAST_MUL_EN
                    state_next = op[1] ? RUN : FIN;
`else
                    state_next = RUN;
`endif
                end
                RUN:  if (count == CW'(WIDTH - 1)) state_next = FIN;
                FIN:  state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count  <= '0;
            done   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            is_div <= 1'b0;
            qsign  <= 1'b0;
            rsign  <= 1'b0;
            opa    <= '0;
            opb    <= '0;
            prod   <= '0;
            rem    <= '0;
            quo    <= '0;
        end else if (flush) begin
            count <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        is_div <= op[1];
                        qsign  <= is_signed & (srca[WIDTH-1] ^ srcb[WIDTH-1]);
                        rsign  <= is_signed & srca[WIDTH-1];
                        opa    <= a_abs;
                        opb    <= b_abs;
                        rem    <= '0;
                        quo    <= a_abs;
                        count  <= '0;
`ifdef MULDIV_FAST_MUL_EN
                        prod   <= op[1] ? {{WIDTH{1'b0}}, b_abs} : fast_prod;
`else
                        prod   <= {{WIDTH{1'b0}}, b_abs};
`endif
                    end else begin
                        if (hiwe) hi <= wd;
                        if (lowe) lo <= wd;
                    end
                end
                RUN: begin
                    count <= count + 1'b1;
                    if (is_div) begin
                        rem <= div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
                        quo <= {quo[WIDTH-2:0], ~div_diff[WIDTH]};
                    end else begin
                        prod <= {mul_sum, prod[WIDTH-1:1]};
                    end
                end
                FIN: begin
                    done <= 1'b1;
                    if (is_div) begin
                        // Divide by zero: remainder has accumulated |srca|, so sign fix restores srca.
                        hi <= rem_fix;
                        lo <= (opb == '0) ? '1 : quo_fix;
                    end else begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases plus random ops vs arithmetic model.
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        reset, start, flush, hiwe, lowe;
    logic [1:0]  op;
    logic [31:0] srca, srcb, wd;
    logic        busy, done;
    logic [31:0] hi, lo;

    int passed = 0;
    int total  = 0;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .srca(srca), .srcb(srcb), .flush(flush), .hiwe(hiwe),
        .lowe(lowe), .wd(wd), .busy(busy), .done(done),
        .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation time limit expired");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference result {hi, lo} from plain arithmetic.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, q, r;
        longint unsigned ua, ub, uq, ur;
        logic [63:0]     qq, rr;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (o)
            2'b00: return 64'(sa * sb);
            2'b01: return ua * ub;
            2'b10: begin
                if (b == 32'd0) return {a, 32'hFFFFFFFF};
                q = sa / sb;
                r = sa % sb;
                qq = q;
                rr = r;
                return {rr[31:0], qq[31:0]};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFFFFFF};
                uq = ua / ub;
                ur = ua % ub;
                return {ur[31:0], uq[31:0]};
            end
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 4))
            0: return $urandom_range(0, 20);
            1: return 32'hFFFFFFFF - $urandom_range(0, 20);
            2: return 32'h80000000;
            default: return $urandom;
        endcase
    endfunction

    // mode 0: plain; mode 1: second start at cycle `at`; mode 2: mthi/mtlo at cycle `at`.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int mode, input int at);
        logic [63:0] exp;
        logic [31:0] hi_before, lo_before;
        int          n;
        int          early_done;
        exp = model(o, a, b);
        hi_before = hi;
        lo_before = lo;
        op = o; srca = a; srcb = b; start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        early_done = 0;
        while (busy && n < 100) begin
            if (done) early_done++;
            start = 1'b0; hiwe = 1'b0; lowe = 1'b0;
            if (mode == 1 && n == at) begin
                start = 1'b1; op = ~o; srca = $urandom; srcb = $urandom;
            end
            if (mode == 2 && n == at) begin
                hiwe = 1'b1; lowe = 1'b1; wd = 32'hDEAD_BEEF;
            end
            if (mode == 2 && n == at + 1)
                chk({tag, " hi/lo held during run"}, {hi, lo}, {hi_before, lo_before});
            tick();
            n++;
        end
        start = 1'b0; hiwe = 1'b0; lowe = 1'b0;
        chk({tag, " busy cycles"}, 64'(n), 64'(o[1] ? DIV_LAT : MUL_LAT));
        chk({tag, " done"}, {63'd0, done}, 64'd1);
        chk({tag, " result"}, {hi, lo}, exp);
        chk({tag, " no early done"}, 64'(early_done), 64'd0);
        tick();
        chk({tag, " done one cycle"}, {63'd0, done}, 64'd0);
    endtask

    initial begin
        int done_seen;
        reset = 1'b0; start = 1'b0; flush = 1'b0; hiwe = 1'b0; lowe = 1'b0;
        op = 2'b00; srca = '0; srcb = '0; wd = '0;
        tick();
        tick();
        chk("reset state", {busy, done, hi, lo}, 66'd0);
        reset = 1'b1;
        tick();

        hiwe = 1'b1; wd = 32'h0000ABCD;
        tick();
        hiwe = 1'b0;
        chk("mthi", {32'd0, hi}, 64'h0000ABCD);
        lowe = 1'b1; wd = 32'h1234_5678;
        tick();
        lowe = 1'b0;
        chk("mtlo", {hi, lo}, 64'h0000ABCD_12345678);

        run_op("MULTU max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0);
        chk("MULTU max const", {hi, lo}, 64'hFFFFFFFE_00000001);
        run_op("MULT -3x7", 2'b00, 32'hFFFFFFFD, 32'd7, 0, 0);
        chk("MULT -3x7 const", {hi, lo}, 64'hFFFFFFFF_FFFFFFEB);
        run_op("DIV -7/2", 2'b10, 32'hFFFFFFF9, 32'd2, 0, 0);
        chk("DIV -7/2 const", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
        run_op("DIVU 100/7", 2'b11, 32'd100, 32'd7, 0, 0);
        run_op("DIVU 5/0", 2'b11, 32'd5, 32'd0, 0, 0);
        chk("DIVU 5/0 const", {hi, lo}, 64'h00000005_FFFFFFFF);
        run_op("DIV -5/0", 2'b10, 32'hFFFFFFFB, 32'd0, 0, 0);
        run_op("DIV ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 0, 0);
        chk("DIV ovf const", {hi, lo}, 64'h00000000_80000000);

        run_op("DIVU restart", 2'b11, 32'd1000, 32'd33, 1, 4);
        run_op("DIV mtlo in run", 2'b10, 32'd12345, 32'hFFFFFFF0, 2, 3);

        for (int i = 0; i < 24; i++)
            run_op("random", 2'($urandom_range(0, 3)), pick(), pick(), 0, 0);

        // flush aborts an in-flight divide
        hiwe = 1'b1; wd = 32'h11;
        tick();
        hiwe = 1'b0;
        op = 2'b11; srca = 32'd9; srcb = 32'd3; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush busy", {63'd0, busy}, 64'd0);
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done) done_seen++;
        end
        chk("flush no done", 64'(done_seen), 64'd0);
        chk("flush hi kept", {32'd0, hi}, 64'h11);

        flush = 1'b1; start = 1'b1; op = 2'b11; srca = 32'd8; srcb = 32'd2;
        tick();
        flush = 1'b0; start = 1'b0;
        chk("flush beats start", {63'd0, busy}, 64'd0);

        // reset mid-multiply
        op = 2'b00; srca = 32'h1234; srcb = 32'h5678; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 19; i++) tick();
        reset = 1'b0;
        tick();
        chk("reset mid-op", {busy, done, hi, lo}, 66'd0);
        reset = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done) done_seen++;
        end
        chk("reset no done", 64'(done_seen), 64'd0);
        run_op("after reset", 2'b01, 32'd6, 32'd7, 0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit that sits downstream of the pipelined MIPS datapath Execute stage.
- Consumes the E-stage operands when multordivE/hlwriteE indicate MULT/MULTU/DIV/DIVU, and owns the HI/LO registers read by mfhi/mflo.
- Drives busy back to the hazard unit, which stalls F/D/E while an operation is in flight.
- Radix-2: one quotient/product bit per cycle.

Parameters:
- WIDTH, 32, operand and HI/LO width; counter width is clog2(WIDTH)+1.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous active-low reset
- start  input  1  begin operation with srca/srcb/op; honoured only in IDLE
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- srca  input  WIDTH  multiplicand / dividend (rs)
- srcb  input  WIDTH  multiplier / divisor (rt)
- flush  input  1  abort in-flight operation (E-stage flush)
- hiwe  input  1  mthi write enable
- lowe  input  1  mtlo write enable
- wd  input  WIDTH  mthi/mtlo write data
- busy  output  1  operation in flight; hazard unit stalls on it
- done  output  1  one-cycle pulse: HI/LO just updated by an operation
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-low. On a clk edge with reset=0: state=IDLE, count=0, hi=0, lo=0, busy=0, done=0.
- States: IDLE, RUN, FIN. busy = (state != IDLE), combinational from state.
- IDLE, start=1 at edge k:
  - Latch op.
  - Latch |srca| and |srcb| for signed ops; raw values for unsigned.
  - Record result signs: quotient/product sign = srca[31]^srcb[31]; remainder sign = srca[31].
  - count=0; state->RUN.
- RUN: one iteration per edge, count++.
  - Multiply: shift-add into a 64-bit accumulator.
  - Divide: restoring shift-subtract, 33-bit partial remainder.
  - Edge where count reaches 32 (edge k+32): state->FIN.
- FIN (edge k+33):
  - Apply sign correction (two's-complement negate where the recorded sign is 1).
  - Multiply: hi = product[63:32], lo = product[31:0].
  - Divide: hi = remainder, lo = quotient.
  - state->IDLE; done registered 1 for exactly the following cycle.
- Latency: busy high for 33 cycles after the start edge. done and the new hi/lo are visible together in the cycle after edge k+33.
- Divide by zero (srcb==0, signed or unsigned): hi=srca (original, unsigned-interpreted), lo=32'hFFFFFFFF. Full latency applies; no exception.
- Signed overflow, DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- start while busy: ignored; in-flight operation unaffected.
- flush=1 (any state, reset=1): state->IDLE, count=0, done=0. hi/lo unchanged. flush has priority over start in the same cycle.
- hiwe/lowe:
  - Honoured only in IDLE, when start=0 and flush=0; update hi/lo at the edge. hiwe and lowe may both be 1.
  - Ignored in RUN/FIN.
  - start=1 with hiwe/lowe=1 in IDLE: start wins and the write is dropped.
- Reset mid-operation: reset overrides flush/start; all state and outputs return to reset values at that edge.
- done never asserts for an aborted (flushed or reset) operation.

Optional Feature:
- Macro: MULDIV_FAST_MUL_EN.
- Defined:
  - MULT/MULTU compute the full 64-bit product combinationally at the start edge, latching it into the accumulator; state goes IDLE->FIN directly.
  - hi/lo written at edge k+1; done visible after edge k+1; busy high 1 cycle.
  - Divide timing unchanged.
- Undefined: multiply uses the 33-cycle iterative path described above.

Test Plan:
- MULTU 0xFFFFFFFF x 0xFFFFFFFF, start at edge 0 -> busy=1 for 33 cycles; done after edge 33 with hi=0xFFFFFFFE, lo=0x00000001 (with MULDIV_FAST_MUL_EN: done after edge 1).
- MULT 0xFFFFFFFD (-3) x 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU 100 / 7 -> lo=14, hi=2.
- DIVU 5 / 0 -> lo=0xFFFFFFFF, hi=5.
- DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- Preload hi=0x11 via mthi; start DIVU 9/3; flush at cycle 10 -> busy=0 next cycle, done never pulses, hi stays 0x11.
- Second start at cycle 5 ignored; the first result is unaltered.
- reset=0 at cycle 20 of a MULT -> hi=lo=0, busy=0, done=0.
- mthi 0xABCD in IDLE -> hi=0xABCD next cycle.
- mtlo asserted during RUN -> lo unchanged.
